// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm annunciator arbiter: FSM states, active codes, pend bit indices.
// latency: n/a; backpressure: n/a.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FIRE     = 3'd1,
    ST_BURGLAR  = 3'd2,
    ST_RAIN     = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  localparam logic [1:0] ACT_NONE = 2'b00;
  localparam logic [1:0] ACT_FIRE = 2'b01;
  localparam logic [1:0] ACT_BURG = 2'b10;
  localparam logic [1:0] ACT_RAIN = 2'b11;

  localparam int FIRE_B = 2;
  localparam int BURG_B = 1;
  localparam int RAIN_B = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [1:0] active_of(input state_t s);
    case (s)
      ST_FIRE:    return ACT_FIRE;
      ST_BURGLAR: return ACT_BURG;
      ST_RAIN:    return ACT_RAIN;
      default:    return ACT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alarm_prio_enc.sv
// Fixed-priority encoder from latched requests to the service state (fire > burglar > rain).
// latency: combinational; backpressure: none.
module alarm_prio_enc
  import alarm_pkg::*;
(
  input  logic [2:0] pend,
  output logic       hit,
  output state_t     svc
);

  always_comb begin
    hit = 1'b1;
    svc = ST_IDLE;
    if (pend[FIRE_B])      svc = ST_FIRE;
    else if (pend[BURG_B]) svc = ST_BURGLAR;
    else if (pend[RAIN_B]) svc = ST_RAIN;
    else                   hit = 1'b0;
  end

endmodule

// File: rtl/alarm_arbiter.sv
// Latches fire/burglar/rain requests and shares one siren and one chime by priority with min on-time.
// latency: 2 cycles request-to-drive, 1 cycle ack-to-quiet; backpressure: none, requests stay latched until serviced.
module alarm_arbiter
  import alarm_pkg::*;
#(
  parameter int MIN_ON    = 8,
  parameter int CHIME_LEN = 4,
  parameter int COOL      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire_alm,
  input  logic       burglar_alm,
  input  logic       rain_alm,
  input  logic       arm,
  input  logic       ack,
  output logic       siren,
  output logic       chime,
  output logic [1:0] active,
  output logic [2:0] pend,
  output logic [2:0] state
);

  localparam int CMAX = max3(MIN_ON, CHIME_LEN, COOL);
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] CNT_SAT    = CW'(CMAX);
  localparam logic [CW-1:0] MIN_ON_C   = CW'(MIN_ON);
  localparam logic [CW-1:0] CHIME_LAST = CW'(CHIME_LEN - 1);
  localparam logic [CW-1:0] COOL_LAST  = CW'(COOL - 1);

  state_t        st;
  state_t        nxt;
  state_t        enc_svc;
  logic          enc_hit;
  logic [CW-1:0] cnt;
  logic [2:0]    clr;
  logic [2:0]    set;
  logic [2:0]    pend_nxt;
  logic          rearm;
  logic          ack_ok;

  alarm_prio_enc u_prio (
    .pend (pend),
    .hit  (enc_hit),
    .svc  (enc_svc)
  );

  always_comb begin
    nxt    = st;
    clr    = 3'b000;
    rearm  = 1'b0;
    ack_ok = ack && (cnt >= MIN_ON_C);
    case (st)
      ST_IDLE: begin
        if (enc_hit) nxt = enc_svc;
      end
      ST_FIRE: begin
        // A still-high fire input re-sets its bit, so service restarts in place.
        if (ack_ok) begin
          clr[FIRE_B] = 1'b1;
          if (fire_alm) rearm = 1'b1;
          else          nxt   = ST_COOLDOWN;
        end
      end
      ST_BURGLAR: begin
        if (pend[FIRE_B]) begin
          nxt = ST_FIRE;
        end else if (!arm || ack_ok) begin
          clr[BURG_B] = 1'b1;
          nxt         = ST_COOLDOWN;
        end
      end
      ST_RAIN: begin
        if (pend[FIRE_B] || pend[BURG_B]) begin
          nxt = enc_svc;
        end else if ((cnt == CHIME_LAST) || ack_ok) begin
          clr[RAIN_B] = 1'b1;
          nxt         = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (pend[FIRE_B])           nxt = ST_FIRE;
        else if (cnt == COOL_LAST)  nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase

    if (!arm) clr[BURG_B] = 1'b1;

    // Set wins over clear for the same bit.
    set      = {fire_alm, burglar_alm & arm, rain_alm};
    pend_nxt = (pend & ~clr) | set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ST_IDLE;
      pend   <= 3'b000;
      cnt    <= '0;
      siren  <= 1'b0;
      chime  <= 1'b0;
      active <= ACT_NONE;
    end else begin
      st     <= nxt;
      pend   <= pend_nxt;
      if ((nxt != st) || rearm) cnt <= '0;
      else if (cnt != CNT_SAT)  cnt <= cnt + 1'b1;
      siren  <= (nxt == ST_FIRE) || (nxt == ST_BURGLAR);
      chime  <= (nxt == ST_RAIN);
      active <= active_of(nxt);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_alarm_arbiter.sv
// Directed self-checking bench for alarm_arbiter with hand-computed expectations.
module tb_alarm_arbiter;

  logic       clk;
  logic       rst;
  logic       fire_alm;
  logic       burglar_alm;
  logic       rain_alm;
  logic       arm;
  logic       ack;
  logic       siren;
  logic       chime;
  logic [1:0] active;
  logic [2:0] pend;
  logic [2:0] state;

  int tests;
  int fails;

  alarm_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .fire_alm    (fire_alm),
    .burglar_alm (burglar_alm),
    .rain_alm    (rain_alm),
    .arm         (arm),
    .ack         (ack),
    .siren       (siren),
    .chime       (chime),
    .active      (active),
    .pend        (pend),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; fire_alm = 1'b0; burglar_alm = 1'b0; rain_alm = 1'b0;
    arm = 1'b1; ack = 1'b0;

    // reset overrides a simultaneous alarm
    fire_alm = 1'b1;
    tick(2);
    check("rst_state", 8'(state), 8'd0);
    check("rst_pend", 8'(pend), 8'd0);
    check("rst_siren", 8'(siren), 8'd0);
    check("rst_chime", 8'(chime), 8'd0);
    check("rst_active", 8'(active), 8'd0);
    fire_alm = 1'b0;
    rst = 1'b0;
    tick(1);

    // rain only: 4-cycle chime, 2 quiet cycles, idle
    rain_alm = 1'b1;
    tick(1);
    check("rain_pend", 8'(pend), 8'b001);
    check("rain_chime_e0", 8'(chime), 8'd0);
    rain_alm = 1'b0;
    tick(1);
    check("rain_chime_on", 8'(chime), 8'd1);
    check("rain_active", 8'(active), 8'b11);
    check("rain_state", 8'(state), 8'd3);
    tick(3);
    check("rain_chime_4th", 8'(chime), 8'd1);
    tick(1);
    check("rain_chime_off", 8'(chime), 8'd0);
    check("rain_cool", 8'(state), 8'd4);
    tick(1);
    check("rain_cool2", 8'(state), 8'd4);
    tick(1);
    check("rain_idle", 8'(state), 8'd0);
    check("rain_pend_clr", 8'(pend), 8'd0);

    // burglar armed: early ack ignored, ack at cnt=8 honoured
    burglar_alm = 1'b1;
    tick(1);
    check("burg_pend", 8'(pend), 8'b010);
    burglar_alm = 1'b0;
    tick(1);
    check("burg_siren", 8'(siren), 8'd1);
    check("burg_active", 8'(active), 8'b10);
    tick(3);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("burg_early_ack", 8'(siren), 8'd1);
    check("burg_early_state", 8'(state), 8'd2);
    tick(4);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("burg_ack_siren", 8'(siren), 8'd0);
    check("burg_ack_pend", 8'(pend), 8'd0);
    check("burg_ack_state", 8'(state), 8'd4);
    tick(2);
    check("burg_idle", 8'(state), 8'd0);

    // burglar while disarmed is ignored
    arm = 1'b0;
    burglar_alm = 1'b1;
    tick(1);
    check("disarm_pend", 8'(pend), 8'd0);
    burglar_alm = 1'b0;
    tick(1);
    check("disarm_siren", 8'(siren), 8'd0);
    check("disarm_state", 8'(state), 8'd0);
    arm = 1'b1;

    // rain preempted by fire, resumes with full chime afterwards
    rain_alm = 1'b1;
    tick(1);
    rain_alm = 1'b0;
    tick(2);
    check("pre_rain_active", 8'(active), 8'b11);
    fire_alm = 1'b1;
    tick(1);
    check("pre_pend", 8'(pend), 8'b101);
    check("pre_still_rain", 8'(active), 8'b11);
    fire_alm = 1'b0;
    tick(1);
    check("pre_fire_active", 8'(active), 8'b01);
    check("pre_fire_siren", 8'(siren), 8'd1);
    check("pre_fire_chime", 8'(chime), 8'd0);
    tick(8);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("pre_ack_state", 8'(state), 8'd4);
    check("pre_ack_pend", 8'(pend), 8'b001);
    tick(2);
    check("pre_idle", 8'(state), 8'd0);
    tick(1);
    check("pre_resume", 8'(active), 8'b11);
    tick(3);
    check("pre_resume_4th", 8'(chime), 8'd1);
    tick(1);
    check("pre_resume_end", 8'(chime), 8'd0);
    check("pre_resume_pend", 8'(pend), 8'd0);
    tick(2);

    // all three at once: fire, burglar, rain in turn
    fire_alm = 1'b1; burglar_alm = 1'b1; rain_alm = 1'b1;
    tick(1);
    check("all_pend", 8'(pend), 8'b111);
    fire_alm = 1'b0; burglar_alm = 1'b0; rain_alm = 1'b0;
    tick(1);
    check("all_active_fire", 8'(active), 8'b01);
    check("all_pend_hold", 8'(pend), 8'b111);
    tick(8);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("all_fire_done", 8'(pend), 8'b011);
    tick(3);
    check("all_active_burg", 8'(active), 8'b10);
    tick(8);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("all_burg_done", 8'(pend), 8'b001);
    tick(3);
    check("all_active_rain", 8'(active), 8'b11);
    tick(4);
    check("all_rain_done", 8'(pend), 8'd0);
    check("all_cool", 8'(state), 8'd4);
    tick(2);

    // fire held at ack: stays in FIRE with counter restarted
    fire_alm = 1'b1;
    tick(2);
    check("hold_fire", 8'(state), 8'd1);
    tick(8);
    ack = 1'b1;
    tick(1);
    check("hold_rearm_state", 8'(state), 8'd1);
    check("hold_rearm_pend", 8'(pend), 8'b100);
    fire_alm = 1'b0;
    tick(3);
    check("hold_ack_ignored", 8'(state), 8'd1);
    ack = 1'b0;
    tick(5);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("hold_done", 8'(state), 8'd4);
    check("hold_quiet", 8'(siren), 8'd0);

    // fire bypasses cooldown
    fire_alm = 1'b1;
    tick(1);
    fire_alm = 1'b0;
    tick(1);
    check("bypass_fire", 8'(state), 8'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;

    // burglar preempted by fire, then disarm in cooldown clears the retained bit
    burglar_alm = 1'b1;
    tick(1);
    burglar_alm = 1'b0;
    tick(1);
    fire_alm = 1'b1;
    tick(1);
    check("bpre_pend", 8'(pend), 8'b110);
    fire_alm = 1'b0;
    tick(1);
    check("bpre_fire", 8'(state), 8'd1);
    check("bpre_retain", 8'(pend), 8'b110);
    tick(8);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    arm = 1'b0;
    tick(1);
    check("disarm_cool_pend", 8'(pend), 8'd0);
    check("disarm_cool_state", 8'(state), 8'd4);
    arm = 1'b1;
    tick(2);
    check("disarm_idle", 8'(state), 8'd0);

    // reset in BURGLAR at service cycle 4
    burglar_alm = 1'b1;
    tick(1);
    burglar_alm = 1'b0;
    tick(5);
    check("rstb_pre", 8'(siren), 8'd1);
    rst = 1'b1;
    tick(1);
    check("rstb_siren", 8'(siren), 8'd0);
    check("rstb_active", 8'(active), 8'd0);
    check("rstb_pend", 8'(pend), 8'd0);
    check("rstb_state", 8'(state), 8'd0);
    rst = 1'b0;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
